// File: rtl/mul_pkg.sv
// Shared types and operand-signedness helpers for the iterative RV M-extension multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    function automatic logic op_is_signed_a(input mul_op_e op);
        return (op != MULHU);
    endfunction

    function automatic logic op_is_signed_b(input mul_op_e op);
        return (op == MUL) || (op == MULH);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BPC shift-add step: adds the partial products of BPC multiplier bits to the accumulator.
module mul_step
    import mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 2
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [2*XLEN-1:0] i_mcand,
    input  logic [BPC-1:0]    i_digit,
    input  logic              i_last,
    input  logic              i_signed_b,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        for (int j = 0; j < BPC; j++) begin
            if (i_digit[j]) begin
                // The top multiplier bit carries weight -2^(XLEN-1) when rs2 is signed.
                if ((j == BPC - 1) && i_last && i_signed_b)
                    w_sum = w_sum - (i_mcand << j);
                else
                    w_sum = w_sum + (i_mcand << j);
            end
        end
    end

    assign o_acc = w_sum;

endmodule

// File: rtl/mul_iter_booth.sv
// Iterative multi-cycle multiplier for MUL/MULH/MULHSU/MULHU with zero early-out and flush.
module mul_iter_booth
    import mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [1:0]      op_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int STEPS = XLEN / BPC;
    localparam int CNT_W = $clog2(STEPS) + 1;

    generate
        if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || ((XLEN % BPC) != 0)) begin : g_bad_param
            $error("mul_iter_booth: BPC must be 1, 2 or 4 and must divide XLEN");
        end
    endgenerate

    mul_state_e          r_state;
    mul_op_e             r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_result;
    logic                r_in_ready;
    logic                r_out_valid;

    logic signed [XLEN:0] w_a_ext;
    logic [2*XLEN-1:0]    w_acc_next;
    logic                 w_last;
    logic                 w_zero;

    function automatic logic [XLEN-1:0] select_half(input mul_op_e op,
                                                    input logic [2*XLEN-1:0] prod);
        return (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign w_a_ext = {op_is_signed_a(mul_op_e'(op_i)) & a_i[XLEN-1], a_i};
    assign w_last  = (r_cnt == CNT_W'(STEPS - 1));
    assign w_zero  = (a_i == '0) || (b_i == '0);

    mul_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .i_digit    (r_mplier[BPC-1:0]),
        .i_last     (w_last),
        .i_signed_b (op_is_signed_b(r_op)),
        .o_acc      (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= MUL;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_op       <= mul_op_e'(op_i);
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        if (w_zero) begin
                            r_state     <= DONE;
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state  <= CALC;
                            r_acc    <= '0;
                            r_mcand  <= {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
                            r_mplier <= b_i;
                        end
                    end
                end
                CALC: begin
                    // Multiplicand walks left while multiplier bits are consumed from the bottom.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << BPC;
                    r_mplier <= r_mplier >> BPC;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_result    <= select_half(r_op, w_acc_next);
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;

endmodule

// File: tb/tb_mul_iter_booth.sv
// Directed and randomized checks of mul_iter_booth against a 64-bit arithmetic reference.
module tb_mul_iter_booth;

    localparam int XLEN = 32;
    localparam int BPC  = 2;
    localparam int NORM_LAT = XLEN / BPC + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [1:0]      op_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_iter_booth #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [63:0] sa, sb, p;
        sa = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (op == 2'b00 || op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single cycle; returns at the falling edge of cycle 1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        @(negedge clk);
        a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid_o !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input int hold, output logic [31:0] res);
        int lat;
        start_op(a, b, op);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'((a == 0 || b == 0) ? 1 : NORM_LAT));
        repeat (hold) @(negedge clk);
        res = result_o;
        check({tag, "_res"}, 64'(res), 64'(ref_mul(a, b, op)));
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, a, b, held;
        logic [1:0]  op;
        logic        seen;
        int          lat;

        rst_n = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0; op_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready_o), 64'(1));
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        rst_n = 1'b1;

        // MUL 7 * -3 with cycle-exact handshake timing
        start_op(32'd7, 32'hFFFF_FFFD, 2'b00);
        for (int k = 1; k < NORM_LAT; k++) begin
            check("t1_busy_ready", 64'(in_ready_o), 64'(0));
            check("t1_busy_valid", 64'(out_valid_o), 64'(0));
            @(negedge clk);
        end
        check("t1_valid", 64'(out_valid_o), 64'(1));
        check("t1_ready_done", 64'(in_ready_o), 64'(0));
        check("t1_result", 64'(result_o), 64'h0000_0000_FFFF_FFEB);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        check("t1_ready_after", 64'(in_ready_o), 64'(1));
        check("t1_valid_after", 64'(out_valid_o), 64'(0));

        // Signed-mode corner products
        run_op("mulh_min", 32'h8000_0000, 32'h8000_0000, 2'b01, 0, res);
        check("mulh_min_const", 64'(res), 64'h4000_0000);
        run_op("mulhu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1, res);
        check("mulhu_ones_const", 64'(res), 64'hFFFF_FFFE);
        run_op("mulhsu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0, res);
        check("mulhsu_ones_const", 64'(res), 64'hFFFF_FFFF);
        run_op("mul_min", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, res);
        run_op("mulhsu_min", 32'h8000_0000, 32'h8000_0000, 2'b10, 0, res);

        // Zero early-out
        run_op("early", 32'h0, 32'h1234_5678, 2'b11, 0, res);
        check("early_const", 64'(res), 64'(0));
        run_op("early_b", 32'hDEAD_BEEF, 32'h0, 2'b01, 2, res);

        // Backpressure in DONE; an extra in_valid pulse must be ignored
        start_op(32'd9, 32'd7, 2'b00);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'(NORM_LAT));
        held = result_o;
        for (int k = 0; k < 5; k++) begin
            in_valid_i = (k == 2);
            a_i = 32'd1; b_i = 32'd1;
            check("bp_valid", 64'(out_valid_o), 64'(1));
            check("bp_result", 64'(result_o), 64'(held));
            check("bp_ready", 64'(in_ready_o), 64'(0));
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        check("bp_value", 64'(held), 64'(63));
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        check("bp_no_second_op", 64'(seen), 64'(0));

        // Flush during CALC cycle 8
        start_op(32'h1234, 32'h5678, 2'b00);
        repeat (7) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_ready", 64'(in_ready_o), 64'(1));
        check("flush_valid", 64'(out_valid_o), 64'(0));
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'(0));
        run_op("after_flush", 32'd3, 32'd5, 2'b00, 0, res);
        check("after_flush_const", 64'(res), 64'(15));

        // Flush coincident with an input handshake drops the op
        @(negedge clk);
        a_i = 32'd3; b_i = 32'd5; op_i = 2'b00; in_valid_i = 1'b1; flush_i = 1'b1;
        check("flush_hs_ready", 64'(in_ready_o), 64'(1));
        @(negedge clk);
        in_valid_i = 1'b0; flush_i = 1'b0;
        check("flush_hs_idle", 64'(in_ready_o), 64'(1));
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        check("flush_hs_no_valid", 64'(seen), 64'(0));

        // Flush in DONE beats a coincident output handshake
        start_op(32'd0, 32'd4, 2'b00);
        check("flush_done_valid", 64'(out_valid_o), 64'(1));
        flush_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; out_ready_i = 1'b0;
        check("flush_done_cleared", 64'(out_valid_o), 64'(0));
        check("flush_done_ready", 64'(in_ready_o), 64'(1));

        // Async reset mid-CALC
        start_op(32'h1234, 32'h10, 2'b00);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_ready", 64'(in_ready_o), 64'(1));
        check("areset_valid", 64'(out_valid_o), 64'(0));
        check("areset_result", 64'(result_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized regression
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = (n % 16 == 0) ? 32'h0 : 32'h1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = (n % 16 == 8) ? 32'h0 : 32'h7FFF_FFFF;
                default: b = $urandom;
            endcase
            op = 2'($urandom);
            run_op("rand", a, b, op, int'($urandom_range(0, 2)), res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
